uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Grants one requester, pulses tx_start, then holds off for a fixed frame window.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 2604,
    parameter int FRAME_BITS   = 12,
    parameter int CNT_W        = 16,
    parameter int ID_W         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [ID_W-1:0]        cur_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam int                 FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    PTR_INIT   = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [ID_W-1:0]      ptr_r, ptr_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s;
    logic                 tx_start_r, tx_start_s;
    logic [7:0]           tx_data_r, tx_data_s;
    logic                 busy_r, busy_s;
    logic [ID_W-1:0]      cur_id_r, cur_id_s;

    logic                 found_s;
    logic [ID_W-1:0]      win_s;
    logic [ID_W-1:0]      scan_s;

    // Round-robin winner: first set request scanning upward from pointer+1, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        scan_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && req[scan_s]) begin
                found_s = 1'b1;
                win_s   = scan_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        ptr_s      = ptr_r;
        gnt_s      = '0;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data_r;
        busy_s     = busy_r;
        cur_id_s   = cur_id_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_s     = REQ_ONE << win_s;
                    tx_data_s = req_data[{win_s, 3'b000} +: 8];
                    cur_id_s  = win_s;
                    ptr_s     = win_s;
                    busy_s    = 1'b1;
                    state_s   = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                tx_start_s = 1'b1;
                cnt_s      = '0;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // Terminal compare keeps the counter from ever reaching its wrap point.
                if (cnt_r == CNT_LAST) begin
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            ptr_r      <= PTR_INIT;
            gnt_r      <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            cur_id_r   <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ptr_r      <= ptr_s;
            gnt_r      <= gnt_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
            cur_id_r   <= cur_id_s;
        end
    end

    assign gnt      = gnt_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign cur_id   = cur_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4, FRAME_BITS=12 (48-cycle window),
// with a small 8N1 transmitter model driven by tx_start/tx_data.
module tb_uart_tx_arbiter;
    localparam int CPB     = 4;
    localparam int FB      = 12;
    localparam int SPACING = CPB * FB + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  cur_id;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .CNT_W(16), .ID_W(2)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    // Transmitter model: 8N1 frame starting the cycle after tx_start, LSB first.
    logic       act_r = 1'b0;
    logic [9:0] sh_r = 10'h3FF;
    int         bit_r = 0;
    int         clk_r = 0;
    int         overlap_r = 0;
    logic       txd;

    always @(posedge clk) begin
        if (reset) begin
            act_r <= 1'b0;
        end else if (tx_start) begin
            if (act_r) overlap_r <= overlap_r + 1;
            sh_r  <= {1'b1, tx_data, 1'b0};
            act_r <= 1'b1;
            bit_r <= 0;
            clk_r <= 0;
        end else if (act_r) begin
            if (clk_r == CPB - 1) begin
                clk_r <= 0;
                sh_r  <= {1'b1, sh_r[9:1]};
                bit_r <= bit_r + 1;
                if (bit_r == 9) act_r <= 1'b0;
            end else begin
                clk_r <= clk_r + 1;
            end
        end
    end
    assign txd = act_r ? sh_r[0] : 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain busy=%b required 0", name, busy);
        end
    endtask

    task automatic rx_frame(output logic [9:0] bits);
        repeat (2) tick();
        bits[0] = txd;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) tick();
            bits[i] = txd;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt, tx_start, tx_data, busy, cur_id} !== 16'h0) begin
            errors++;
            $display("FAIL reset gnt=%b tx_start=%b tx_data=%h busy=%b cur_id=%0d required all 0",
                     gnt, tx_start, tx_data, busy, cur_id);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int n, extra;
        do_reset();
        req_data = 32'h00A50000;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || cur_id !== 2'd2 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_grant gnt=%b busy=%b cur_id=%0d tx_start=%b required 0100/1/2/0",
                     gnt, busy, cur_id, tx_start);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_launch tx_start=%b tx_data=%h gnt=%b required 1/a5/0000",
                     tx_start, tx_data, gnt);
        end
        n = 0;
        extra = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (tx_start) extra++;
        end
        checks++;
        if (n != CPB * FB) begin
            errors++;
            $display("FAIL single_window wait_cycles=%0d required %0d", n, CPB * FB);
        end
        checks++;
        if (extra != 0 || cur_id !== 2'd2 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold extra_starts=%0d cur_id=%0d tx_data=%h required 0/2/a5",
                     extra, cur_id, tx_data);
        end
    endtask

    task automatic test_all_active;
        int exp_id[5]   = '{0, 1, 2, 3, 0};
        logic [7:0] exp_b[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        int cyc, nstart, ngnt, last, multi;
        do_reset();
        req_data = 32'h43322110;
        req = 4'hF;
        cyc = 0; nstart = 0; ngnt = 0; last = 0; multi = 0;
        while (nstart < 5 && cyc < 400) begin
            tick();
            cyc++;
            if ($countones(gnt) > 1) multi++;
            if (gnt !== 4'b0000) begin
                if (ngnt < 5) begin
                    checks++;
                    if (cur_id !== 2'(exp_id[ngnt]) || gnt !== (4'b0001 << exp_id[ngnt])) begin
                        errors++;
                        $display("FAIL rr_order[%0d] gnt=%b cur_id=%0d required id %0d",
                                 ngnt, gnt, cur_id, exp_id[ngnt]);
                    end
                end
                ngnt++;
            end
            if (tx_start) begin
                checks++;
                if (tx_data !== exp_b[nstart]) begin
                    errors++;
                    $display("FAIL rr_data[%0d] tx_data=%h required %h", nstart, tx_data, exp_b[nstart]);
                end
                if (nstart > 0) begin
                    checks++;
                    if (cyc - last != SPACING) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d] gap=%0d required %0d", nstart, cyc - last, SPACING);
                    end
                end
                last = cyc;
                nstart++;
            end
        end
        checks++;
        if (nstart != 5) begin
            errors++;
            $display("FAIL rr_timeout starts=%0d required 5", nstart);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL rr_onehot multi_gnt_cycles=%0d required 0", multi);
        end
        req = 4'h0;
        drain("rr");
    endtask

    task automatic test_wait_request;
        int n, bad;
        do_reset();
        req_data = 32'h99000010;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        repeat (10) tick();
        req = 4'b1000;
        n = 0;
        bad = 0;
        while (busy && n < 200) begin
            if (gnt !== 4'b0000 || tx_data !== 8'h10) bad++;
            tick();
            n++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_ignore bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (gnt !== 4'b0000 || tx_data !== 8'h10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle gnt=%b tx_data=%h busy=%b required 0000/10/0", gnt, tx_data, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || cur_id !== 2'd3 || tx_data !== 8'h99 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_regrant gnt=%b cur_id=%0d tx_data=%h busy=%b required 1000/3/99/1",
                     gnt, cur_id, tx_data, busy);
        end
        req = 4'b0000;
        drain("wait");
    endtask

    task automatic test_drop_before_grant;
        int ngnt, nstart;
        do_reset();
        req_data = 32'h00002110;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        repeat (5) tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        ngnt = 0;
        nstart = 0;
        for (int i = 0; i < 60; i++) begin
            if (gnt !== 4'b0000) ngnt++;
            if (tx_start) nstart++;
            tick();
        end
        checks++;
        if (ngnt != 0 || nstart != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop grants=%0d starts=%0d busy=%b required 0/0/0", ngnt, nstart, busy);
        end
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        req_data = 32'h43322110;
        req = 4'hF;
        tick();
        tick();
        repeat (20) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || cur_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_wait gnt=%b tx_start=%b busy=%b tx_data=%h cur_id=%0d required all 0",
                     gnt, tx_start, busy, tx_data, cur_id);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || cur_id !== 2'd0 || tx_data !== 8'h10) begin
            errors++;
            $display("FAIL rst_wait_next gnt=%b cur_id=%0d tx_data=%h required 0001/0/10",
                     gnt, cur_id, tx_data);
        end
        req = 4'h0;
        drain("rst_wait");
    endtask

    task automatic test_integration;
        int n;
        logic [9:0] bits;
        do_reset();
        req_data = 32'h00004F00;
        req = 4'b0010;
        n = 0;
        while (gnt === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL int_gnt1 gnt=%b required 0010", gnt);
        end
        req_data = 32'h00004B00;
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h4F) begin
            errors++;
            $display("FAIL int_start1 tx_start=%b tx_data=%h required 1/4f", tx_start, tx_data);
        end
        rx_frame(bits);
        checks++;
        if (bits !== {1'b1, 8'h4F, 1'b0}) begin
            errors++;
            $display("FAIL int_frame1 bits=%b required %b", bits, {1'b1, 8'h4F, 1'b0});
        end
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (gnt !== 4'b0000) req = 4'b0000;
        end
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h4B || act_r !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL int_start2 tx_start=%b tx_data=%h line_active=%b txd=%b required 1/4b/0/1",
                     tx_start, tx_data, act_r, txd);
        end
        rx_frame(bits);
        checks++;
        if (bits !== {1'b1, 8'h4B, 1'b0}) begin
            errors++;
            $display("FAIL int_frame2 bits=%b required %b", bits, {1'b1, 8'h4B, 1'b0});
        end
        checks++;
        if (overlap_r != 0) begin
            errors++;
            $display("FAIL int_overlap overlaps=%0d required 0", overlap_r);
        end
        req = 4'b0000;
        drain("int");
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_all_active();
        test_wait_request();
        test_drop_before_grant();
        test_reset_in_wait();
        test_integration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
